// File: rtl/mem_wb_pipe_if.sv
// MEM->WB stage handshake bundle: upstream valid/ready plus entry fields,
// downstream valid/ready plus head-entry fields.
// The master modport is the side that drives MEM entries and consumes WB
// output. The slave modport is the pipeline stage itself.
interface mem_wb_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  // Upstream (MEM side)
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_readdata;
  logic [DATA_W-1:0] in_aluresult;
  logic [REG_W-1:0]  in_rd;
  logic              in_memtoreg;
  logic              in_regwrite;

  // Downstream (WB side)
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_readdata;
  logic [DATA_W-1:0] out_aluresult;
  logic [REG_W-1:0]  out_rd;
  logic              out_memtoreg;
  logic              out_regwrite;
  logic [DATA_W-1:0] out_wbdata;

  modport master (
    output in_valid, in_readdata, in_aluresult, in_rd, in_memtoreg,
           in_regwrite, out_ready,
    input  in_ready, out_valid, out_readdata, out_aluresult, out_rd,
           out_memtoreg, out_regwrite, out_wbdata
  );

  modport slave (
    input  in_valid, in_readdata, in_aluresult, in_rd, in_memtoreg,
           in_regwrite, out_ready,
    output in_ready, out_valid, out_readdata, out_aluresult, out_rd,
           out_memtoreg, out_regwrite, out_wbdata
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage with a valid/ready handshake and a 2-entry skid
// buffer.
//
// Entry M drives the outputs. Entry S catches the entry that is accepted
// while M is stalled. in_ready comes from a flop, so there is no
// combinational path from out_ready to in_ready.
//
// Writes to register 0 are suppressed when an entry is captured. flush
// drops every held entry and the entry offered in the same cycle.
//
// Optional feature macro: MEM_WB_PIPE_WBMUX_EN.
// When it is defined, the writeback value (memtoreg ? readdata : aluresult)
// is computed at capture and stored with each entry. When it is undefined,
// out_wbdata is tied to 0 and WB does its own mux.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           flush,
  mem_wb_pipe_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // M invalid, S invalid
    ONE   = 2'd1,  // M valid,   S invalid
    FULL  = 2'd2   // M valid,   S valid
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] readdata;
    logic [DATA_W-1:0] aluresult;
`ifdef MEM_WB_PIPE_WBMUX_EN
    logic [DATA_W-1:0] wbdata;
`endif
    logic [REG_W-1:0]  rd;
    logic              memtoreg;
    logic              regwrite;
  } entry_t;

  state_e state_q, state_d;
  entry_t m_q, m_d;
  entry_t s_q, s_d;
  logic   in_ready_q, in_ready_d;

  logic   m_valid;
  logic   accept;
  logic   pop;
  entry_t cap;

  assign m_valid = (state_q != EMPTY);
  assign accept  = bus.in_valid & in_ready_q;
  assign pop     = m_valid & bus.out_ready;

  // Shape the incoming entry: drop regwrite for r0 and pre-select the writeback value.
  always_comb begin
    cap           = '0;
    cap.readdata  = bus.in_readdata;
    cap.aluresult = bus.in_aluresult;
    cap.rd        = bus.in_rd;
    cap.memtoreg  = bus.in_memtoreg;
    cap.regwrite  = bus.in_regwrite & (bus.in_rd != '0);
`ifdef MEM_WB_PIPE_WBMUX_EN
    cap.wbdata    = bus.in_memtoreg ? bus.in_readdata : bus.in_aluresult;
`endif
  end

  // Next-state logic: skid-buffer occupancy and entry movement.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path through the block can leave a latch behind.
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          m_d     = cap;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          m_d = cap;
        end else if (accept) begin
          s_d     = cap;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          m_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush wins over accept and pop. The stored data is left alone because
    // it is ignored while invalid.
    if (flush) begin
      state_d = EMPTY;
      m_d     = m_q;
      s_d     = s_q;
    end

    in_ready_d = (state_d != FULL);
  end

  // State and storage registers; reset clears everything so all outputs read 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the entry data is reset as well as the valid bits, because every output, data included, must read 0 after reset.
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      s_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments, so each register samples the pre-edge value of the others.
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_q        <= m_d;
      s_q        <= s_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = m_valid;
  assign bus.out_readdata  = m_q.readdata;
  assign bus.out_aluresult = m_q.aluresult;
  assign bus.out_rd        = m_q.rd;
  assign bus.out_memtoreg  = m_q.memtoreg;
  assign bus.out_regwrite  = m_q.regwrite & m_valid;
`ifdef MEM_WB_PIPE_WBMUX_EN
  assign bus.out_wbdata    = m_q.wbdata;
`else
  assign bus.out_wbdata    = '0;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe.
// Expected entries are pushed to a scoreboard queue when the bench observes
// an accept. A monitor pops one entry on every observed pop and compares it
// with the DUT output. The scenario tasks also check handshake timing and
// boundary behaviour directly.
module tb_mem_wb_pipe;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
`ifdef MEM_WB_PIPE_WBMUX_EN
  localparam bit WBMUX = 1'b1;
`else
  localparam bit WBMUX = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wb;
    logic [REG_W-1:0]  rd;
    logic              mtr;
    logic              rw;
  } exp_t;

  logic clk;
  logic reset;
  logic flush;
  int   total;
  int   bad;
  exp_t sb[$];

  mem_wb_pipe_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  mem_wb_pipe #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clock (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor. It samples at the negative edge, halfway between
  // input changes (posedge+1) and the next active edge.
  always @(negedge clk) begin
    exp_t e;
    exp_t n;
    total++;
    if (bus.out_regwrite === 1'b1 && bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL regwrite_gate: out_regwrite=%b with out_valid=%b", bus.out_regwrite, bus.out_valid);
    end
    if (reset) begin
      sb.delete();
    end else begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: alu=%h rd=%0d with empty scoreboard", bus.out_aluresult, bus.out_rd);
        end else begin
          e = sb.pop_front();
          if ({bus.out_readdata, bus.out_aluresult, bus.out_wbdata, bus.out_rd, bus.out_memtoreg, bus.out_regwrite}
              !== {e.rdata, e.alu, e.wb, e.rd, e.mtr, e.rw}) begin
            bad++;
            $display("FAIL out_entry: got rdata=%h alu=%h wb=%h rd=%0d mtr=%b rw=%b want rdata=%h alu=%h wb=%h rd=%0d mtr=%b rw=%b",
                     bus.out_readdata, bus.out_aluresult, bus.out_wbdata, bus.out_rd, bus.out_memtoreg, bus.out_regwrite,
                     e.rdata, e.alu, e.wb, e.rd, e.mtr, e.rw);
          end
        end
      end
      if (flush) begin
        sb.delete();
      end else if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        n.rdata = bus.in_readdata;
        n.alu   = bus.in_aluresult;
        n.rd    = bus.in_rd;
        n.mtr   = bus.in_memtoreg;
        n.rw    = bus.in_regwrite && (bus.in_rd != 0);
        n.wb    = WBMUX ? (bus.in_memtoreg ? bus.in_readdata : bus.in_aluresult) : '0;
        sb.push_back(n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] alu,
                       input logic [DATA_W-1:0] rdata, input logic mtr, input logic rw);
    bus.in_valid     = 1'b1;
    bus.in_rd        = rd;
    bus.in_aluresult = alu;
    bus.in_readdata  = rdata;
    bus.in_memtoreg  = mtr;
    bus.in_regwrite  = rw;
  endtask

  task automatic idle();
    bus.in_valid     = 1'b0;
    bus.in_rd        = 'x;
    bus.in_aluresult = 'x;
    bus.in_readdata  = 'x;
    bus.in_memtoreg  = 1'bx;
    bus.in_regwrite  = 1'bx;
  endtask

  // Let WB consume until the scoreboard is empty. An expired budget counts as a failure.
  task automatic drain(input string name);
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d entries still pending, want 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    total++;
    if ({bus.out_valid, bus.out_regwrite, bus.out_memtoreg, bus.out_readdata, bus.out_aluresult, bus.out_rd, bus.out_wbdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b rw=%b mtr=%b rdata=%h alu=%h rd=%0d wb=%h want all 0",
               bus.out_valid, bus.out_regwrite, bus.out_memtoreg, bus.out_readdata, bus.out_aluresult, bus.out_rd, bus.out_wbdata);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] alu;
    bus.out_ready = 1'b1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_pre_valid: got %b want 0", bus.out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      alu = 32'h11 * (i + 1);
      drive(REG_W'(i + 1), alu, 32'h100 + i, 1'b0, 1'b1);
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_in_ready[%0d]: got %b want 1", i, bus.in_ready);
      end
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_aluresult !== alu) begin
        bad++;
        $display("FAIL stream_latency[%0d]: valid=%b alu=%h want valid=1 alu=%h", i, bus.out_valid, bus.out_aluresult, alu);
      end
    end
    idle();
    drain("stream");
  endtask

  task automatic test_back_pressure();
    bit took_c0;
    bus.out_ready = 1'b0;
    drive(5'd6, 32'hA0, 32'h0, 1'b0, 1'b1);
    tick();
    drive(5'd7, 32'hB0, 32'h0, 1'b0, 1'b1);
    tick();
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_in_ready_full: got %b want 0", bus.in_ready);
    end
    drive(5'd8, 32'hC0, 32'h0, 1'b0, 1'b1);
    repeat (2) tick();
    total++;
    if (bus.in_ready !== 1'b0 || bus.out_aluresult !== 32'hA0) begin
      bad++;
      $display("FAIL bp_hold: in_ready=%b alu=%h want in_ready=0 alu=a0", bus.in_ready, bus.out_aluresult);
    end
    bus.out_ready = 1'b1;
    took_c0 = 1'b0;
    for (int n = 0; n < 6 && !took_c0; n++) begin
      if (bus.in_ready === 1'b1) took_c0 = 1'b1;
      tick();
    end
    total++;
    if (!took_c0) begin
      bad++;
      $display("FAIL bp_accept_c0: in_ready never rose, want accept within 6 cycles");
    end
    idle();
    drain("bp");
  endtask

  task automatic test_r0();
    bus.out_ready = 1'b0;
    drive(5'd0, 32'hDEAD, 32'h0, 1'b0, 1'b1);
    tick();
    idle();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd0 || bus.out_regwrite !== 1'b0) begin
      bad++;
      $display("FAIL r0_suppress: valid=%b rd=%0d rw=%b want valid=1 rd=0 rw=0", bus.out_valid, bus.out_rd, bus.out_regwrite);
    end
    drain("r0");
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(5'd9, 32'h61, 32'h0, 1'b0, 1'b1);
    tick();
    drive(5'd10, 32'h62, 32'h0, 1'b0, 1'b1);
    tick();
    drive(5'd11, 32'h77, 32'h0, 1'b0, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_state: valid=%b in_ready=%b want valid=0 in_ready=1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_no_0x77[%0d]: valid=%b alu=%h want valid=0", n, bus.out_valid, bus.out_aluresult);
      end
    end
  endtask

  task automatic test_reset_full();
    bus.out_ready = 1'b0;
    drive(5'd12, 32'h81, 32'h0, 1'b1, 1'b1);
    tick();
    drive(5'd13, 32'h82, 32'h0, 1'b1, 1'b1);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({bus.out_valid, bus.out_regwrite, bus.out_memtoreg, bus.out_readdata, bus.out_aluresult, bus.out_rd, bus.out_wbdata} !== '0
        || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_full: valid=%b rw=%b mtr=%b rdata=%h alu=%h rd=%0d wb=%h in_ready=%b want all 0 and in_ready=1",
               bus.out_valid, bus.out_regwrite, bus.out_memtoreg, bus.out_readdata, bus.out_aluresult, bus.out_rd,
               bus.out_wbdata, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    drive(5'd14, 32'h55, 32'h0, 1'b0, 1'b1);
    tick();
    idle();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_aluresult !== 32'h55) begin
      bad++;
      $display("FAIL reset_full_resume: valid=%b alu=%h want valid=1 alu=55", bus.out_valid, bus.out_aluresult);
    end
    drain("reset_full");
  endtask

  task automatic test_wbmux();
    logic [DATA_W-1:0] want;
    for (int m = 1; m >= 0; m--) begin
      bus.out_ready = 1'b0;
      drive(5'd4, 32'h5678, 32'h1234, m[0], 1'b1);
      tick();
      idle();
      want = WBMUX ? ((m == 1) ? 32'h1234 : 32'h5678) : 32'h0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_wbdata !== want) begin
        bad++;
        $display("FAIL wbmux_mtr%0d: valid=%b wbdata=%h want valid=1 wbdata=%h", m, bus.out_valid, bus.out_wbdata, want);
      end
      drain("wbmux");
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    test_reset();
    test_stream();
    test_back_pressure();
    test_r0();
    test_flush();
    test_reset_full();
    test_wbmux();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
